// File: rtl/fft_spi_frame_scheduler_pkg.sv
// Shared definitions for the FFT-to-SPI frame scheduler: default geometry and FSM encoding.
package fft_spi_frame_scheduler_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } sched_state_t;

  // Zero-length waits make no sense in hardware; clamp them to one cycle.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// One-deep pending frame store between the FFT stage and the scheduler FSM.
module fft_frame_buffer #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          ovf
);

  // A write is accepted when the slot is empty or is being drained this cycle.
  logic accept;
  assign accept = wr && (!valid || rd);
  assign ovf    = wr && valid && !rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (accept) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (rd) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft_spi_frame_scheduler.sv
// Buffers FFT frames, launches them into fft_spi_out, follows cs and enforces the inter-frame gap.
module fft_spi_frame_scheduler
  import fft_spi_frame_scheduler_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int W           = DEF_W,
  parameter int GAP_CYCLES  = 64,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fft_valid,
  input  logic [N*W-1:0] fft_data,
  input  logic           spi_cs,
  input  logic           clr_flags,
  output logic [N*W-1:0] data_bus,
  output logic           start_spi,
  output logic           busy,
  output logic [15:0]    frame_cnt,
  output logic           overrun,
  output logic           timeout
);

  localparam int GAP_LIM = at_least_one(GAP_CYCLES);
  localparam int ACK_LIM = at_least_one(ACK_TIMEOUT);
  localparam int CNT_MAX = (GAP_LIM > ACK_LIM) ? GAP_LIM : ACK_LIM;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t     state;
  logic [CNT_W-1:0] ack_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             spi_cs_q;
  logic [N*W-1:0]   pend_data;
  logic             pend_v;
  logic             buf_rd;
  logic             buf_ovf;

  assign buf_rd = (state == ST_IDLE) && pend_v;

  fft_frame_buffer #(
    .DW(N*W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (fft_valid),
    .din  (fft_data),
    .rd   (buf_rd),
    .dout (pend_data),
    .valid(pend_v),
    .ovf  (buf_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (buf_ovf) begin
      overrun <= 1'b1;
    end else if (clr_flags) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_bus  <= '0;
      start_spi <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
      timeout   <= 1'b0;
      ack_cnt   <= '0;
      gap_cnt   <= '0;
      spi_cs_q  <= 1'b1;
    end else begin
      spi_cs_q  <= spi_cs;
      start_spi <= 1'b0;
      // A timeout raised below in the same cycle overrides this clear.
      if (clr_flags) begin
        timeout <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (pend_v) begin
            data_bus <= pend_data;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          start_spi <= 1'b1;
          ack_cnt   <= '0;
          state     <= ST_ARM;
        end
        ST_ARM: begin
          if (!spi_cs) begin
            state <= ST_SEND;
          end else if (ack_cnt == CNT_W'(ACK_LIM - 1)) begin
            timeout <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (!spi_cs_q && spi_cs) begin
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == CNT_W'(GAP_LIM - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_spi_frame_scheduler.sv
// Scoreboard bench: a one-slot frame model predicts which frames get launched; a monitor checks each start.
module tb_fft_spi_frame_scheduler;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int BW  = N * W;
  localparam int GAP = 64;
  localparam int ACK = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fft_valid = 1'b0;
  logic [BW-1:0] fft_data = '0;
  logic          spi_cs = 1'b1;
  logic          clr_flags = 1'b0;
  logic [BW-1:0] data_bus;
  logic          start_spi;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic          timeout;

  fft_spi_frame_scheduler #(
    .N(N), .W(W), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_data (fft_data),
    .spi_cs   (spi_cs),
    .clr_flags(clr_flags),
    .data_bus (data_bus),
    .start_spi(start_spi),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Model: frames accepted but not yet launched (capacity one), expected counters and flags.
  logic [BW-1:0] exp_q[$];
  logic [15:0]   m_frames = 16'd0;
  logic          m_overrun = 1'b0;
  logic          m_timeout = 1'b0;

  int   start_count    = 0;
  int   last_start_cyc = -1000;
  int   last_rise_cyc  = -1000;
  int   t_issue        = 0;
  bit   hold_cs        = 1'b0;
  int   cs_delay       = 2;
  int   low_len        = 128;
  logic prev_start     = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=bound expired expected=event", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [BW-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every start pulse is one transaction checked against the head of the queue.
  always @(negedge clk) begin
    logic [BW-1:0] f;
    if (!rst && start_spi) begin
      start_count++;
      check("start_width", BW'(prev_start), '0);
      if (last_rise_cyc > last_start_cyc) begin
        checks++;
        if (cyc - last_rise_cyc < GAP) begin
          errors++;
          $display("FAIL gap cyc=%0d got=%0d expected>=%0d", cyc, cyc - last_rise_cyc, GAP);
        end
      end
      last_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start cyc=%0d got=start_spi expected=no start", cyc);
      end else begin
        f = exp_q.pop_front();
        check("data_bus", data_bus, f);
      end
      $display("start_spi cyc=%0d data_bus=%h frame_cnt=%0d", cyc, data_bus, frame_cnt);
    end
    prev_start = start_spi;
  end

  // SPI side: after each start, drop cs after cs_delay cycles and hold it low for low_len.
  always begin
    @(negedge clk);
    if (!rst && start_spi && !hold_cs) begin
      repeat (cs_delay) @(negedge clk);
      spi_cs = 1'b0;
      repeat (low_len) @(negedge clk);
      spi_cs = 1'b1;
      last_rise_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d got=no finish expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [BW-1:0] d);
    bit queued;
    @(negedge clk);
    fft_valid = 1'b1;
    fft_data  = d;
    t_issue   = cyc;
    queued    = (exp_q.size() == 0);
    if (queued) exp_q.push_back(d);
    else m_overrun = 1'b1;
    $display("fft_valid cyc=%0d data=%h %s", cyc, d, queued ? "queued" : "dropped");
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    m_overrun = 1'b0;
    m_timeout = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input int prev, input int budget);
    int n = 0;
    while (start_count == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (start_count == prev) fail_msg("wait_start");
  endtask

  task automatic wait_cs(input logic lvl, input int budget);
    int n = 0;
    while (spi_cs !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (spi_cs !== lvl) fail_msg("wait_cs");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) fail_msg("wait_idle");
  endtask

  // One complete SPI frame, with k extra FFT frames arriving while cs is low.
  task automatic run_frame(input int sc, input int k);
    wait_start(sc, 300);
    wait_cs(1'b0, 40);
    for (int i = 0; i < k; i++) begin
      tick($urandom_range(2, 6));
      issue(rand_frame());
    end
    wait_cs(1'b1, 200);
    m_frames = m_frames + 16'd1;
    tick(2);
    check("frame_cnt", BW'(frame_cnt), BW'(m_frames));
  endtask

  task automatic idle_checks();
    wait_idle(200);
    check("frame_cnt_idle", BW'(frame_cnt), BW'(m_frames));
    check("overrun", BW'(overrun), BW'(m_overrun));
    check("timeout", BW'(timeout), BW'(m_timeout));
  endtask

  initial begin
    int sc;
    int a;
    tick(3);
    check("rst_data_bus", data_bus, '0);
    check("rst_start", BW'(start_spi), '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_frame_cnt", BW'(frame_cnt), '0);
    check("rst_flags", BW'({overrun, timeout}), '0);
    rst = 1'b0;
    tick(2);

    // Single frame with a long cs-low phase, checking launch latency.
    cs_delay = 2;
    low_len  = 128;
    sc = start_count;
    issue(128'h0807060504030201);
    wait_start(sc, 20);
    check("latency", BW'(last_start_cyc - t_issue), BW'(3));
    wait_cs(1'b0, 40);
    wait_cs(1'b1, 200);
    m_frames = m_frames + 16'd1;
    tick(2);
    check("frame_cnt", BW'(frame_cnt), BW'(m_frames));
    check("busy_in_gap", BW'(busy), BW'(1));
    idle_checks();

    // Frame arriving during SEND waits, then goes out after the gap.
    cs_delay = 3;
    low_len  = 40;
    sc = start_count;
    issue(rand_frame());
    run_frame(sc, 1);
    run_frame(start_count, 0);
    idle_checks();

    // Two frames during SEND: the second of them is dropped.
    sc = start_count;
    issue(rand_frame());
    run_frame(sc, 2);
    run_frame(start_count, 0);
    idle_checks();
    clear_flags();
    check("overrun_clr", BW'(overrun), '0);

    // No cs response: timeout fires on the 32nd ARM cycle, no frame counted.
    hold_cs = 1'b1;
    sc = start_count;
    issue(rand_frame());
    wait_start(sc, 20);
    a = last_start_cyc;
    while (cyc < a + ACK - 1) @(negedge clk);
    check("timeout_early", BW'(timeout), '0);
    @(negedge clk);
    m_timeout = 1'b1;
    check("timeout_set", BW'(timeout), BW'(1));
    idle_checks();
    hold_cs = 1'b0;
    clear_flags();
    check("timeout_clr", BW'(timeout), '0);

    // Reset while sending with a frame pending.
    cs_delay = 2;
    low_len  = 50;
    sc = start_count;
    issue(rand_frame());
    wait_start(sc, 20);
    wait_cs(1'b0, 40);
    issue(rand_frame());
    tick(3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_frames  = 16'd0;
    m_overrun = 1'b0;
    m_timeout = 1'b0;
    check("rst_mid_bus", data_bus, '0);
    check("rst_mid_outs", BW'({start_spi, busy, overrun, timeout}), '0);
    check("rst_mid_cnt", BW'(frame_cnt), '0);
    @(negedge clk);
    rst = 1'b0;
    sc = start_count;
    wait_cs(1'b1, 200);
    tick(150);
    check("no_start_after_rst", BW'(start_count), BW'(sc));

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      if (exp_q.size() == 0) begin
        idle_checks();
        if (m_overrun) clear_flags();
        cs_delay = $urandom_range(1, 6);
        low_len  = $urandom_range(30, 70);
        sc = start_count;
        issue(rand_frame());
      end else begin
        sc = start_count;
      end
      run_frame(sc, $urandom_range(0, 3));
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) run_frame(start_count, 0);
    idle_checks();
    clear_flags();

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    m_frames = 16'hFFFF;
    sc = start_count;
    issue(rand_frame());
    run_frame(sc, 0);
    idle_checks();
    check("wrap", BW'(frame_cnt), '0);

    check("queue_empty", BW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
